// File: rtl/ram_responder_pkg.sv
// Shared tinyCPU constants: IO window addresses and IO FIFO geometry.
package ram_responder_pkg;
  localparam logic [7:0] IO_DATA_ADDR  = 8'hFF;
  localparam logic [7:0] IO_STAT_ADDR  = 8'hFE;
  localparam int         IO_FIFO_DEPTH = 4;
  localparam int         IO_PTR_W      = 2;
  localparam int         IO_CNT_W      = IO_PTR_W + 1;
endpackage

// File: rtl/io_fifo.sv
// 4-entry output FIFO behind the IO data port; a push into a full FIFO is
// still taken when a pop frees the head in the same cycle.
module io_fifo
  import ram_responder_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [7:0]          wdata_i,
  output logic [7:0]          head_o,
  output logic                full_o,
  output logic [IO_CNT_W-1:0] count_o
);
  logic [7:0]          buf_q [IO_FIFO_DEPTH];
  logic [IO_PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [IO_CNT_W-1:0] count_q, count_d;
  logic                do_push, do_pop;

  assign full_o  = (count_q == IO_CNT_W'(IO_FIFO_DEPTH));
  assign count_o = count_q;
  assign head_o  = buf_q[rptr_q];
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Entries carry no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (!rst && do_push) buf_q[wptr_q] <= wdata_i;
  end
endmodule

// File: rtl/ram_responder.sv
// 256x8 zero-latency RAM for the tinyCPU. With RAM_IO_FIFO_EN defined,
// 8'hFF becomes the IO FIFO data port / overflow counter and 8'hFE the status.
module ram_responder
  import ram_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ram_addr,
  input  logic [7:0] ram_wdat,
  output logic [7:0] ram_rdat,
  input  logic       ram_rd_,
  input  logic       ram_wr_,
  output logic [7:0] io_data,
  output logic       io_valid,
  input  logic       io_ready
);
  logic [7:0] mem_q [256];
  logic       io_hit;

`ifdef RAM_IO_FIFO_EN
  logic                push, pop, full;
  logic [IO_CNT_W-1:0] count;
  logic [7:0]          head, ovf_q, ovf_d;

  assign io_hit = (ram_addr == IO_DATA_ADDR) || (ram_addr == IO_STAT_ADDR);
  assign push   = !ram_wr_ && (ram_addr == IO_DATA_ADDR);
  assign pop    = io_valid && io_ready;

  io_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (ram_wdat),
    .head_o  (head),
    .full_o  (full),
    .count_o (count)
  );

  assign io_valid = (count != '0);
  assign io_data  = head;

  always_comb begin
    ovf_d = ovf_q;
    if (push && full && !pop && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= '0;
    else     ovf_q <= ovf_d;
  end
`else
  logic unused_io_ready;
  assign unused_io_ready = io_ready;
  assign io_hit   = 1'b0;
  assign io_valid = 1'b0;
  assign io_data  = 8'h00;
`endif

  // Read is combinational off the pre-edge array, so a same-cycle write
  // shows the old value now and the new one next cycle.
  always_comb begin
    ram_rdat = 8'h00;
    if (!ram_rd_) begin
`ifdef RAM_IO_FIFO_EN
      if (ram_addr == IO_DATA_ADDR)      ram_rdat = ovf_q;
      else if (ram_addr == IO_STAT_ADDR) ram_rdat = {{(8-IO_CNT_W){1'b0}}, count};
      else                               ram_rdat = mem_q[ram_addr];
`else
      ram_rdat = mem_q[ram_addr];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !ram_wr_ && !io_hit) mem_q[ram_addr] <= ram_wdat;
  end
endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder; covers both RAM_IO_FIFO_EN builds.
module tb_ram_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ram_addr, ram_wdat, ram_rdat, io_data;
  logic       ram_rd_, ram_wr_, io_valid, io_ready;
  int         ncmp = 0;
  int         nfail = 0;

  // reference model
  logic [7:0] mem_m [256];
  bit         known_m [256];
  logic [7:0] fifo_m [$];
  int         ovf_m;

  always #5 clk = ~clk;

  ram_responder dut (
    .clk(clk), .rst(rst), .ram_addr(ram_addr), .ram_wdat(ram_wdat),
    .ram_rdat(ram_rdat), .ram_rd_(ram_rd_), .ram_wr_(ram_wr_),
    .io_data(io_data), .io_valid(io_valid), .io_ready(io_ready)
  );

  task automatic drive(input logic [7:0] a, input logic [7:0] d,
                       input logic rd_n, input logic wr_n, input logic rdy);
    ram_addr = a; ram_wdat = d; ram_rd_ = rd_n; ram_wr_ = wr_n; io_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick(); tick();
    rst = 1'b0; idle();
    ncmp++; if (io_valid !== 1'b0) begin nfail++; $display("FAIL reset_io_valid got %h want 0", io_valid); end
    ncmp++; if (ram_rdat !== 8'h00) begin nfail++; $display("FAIL reset_rdat_idle got %h want 00", ram_rdat); end
`ifdef RAM_IO_FIFO_EN
    drive(8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'h00) begin nfail++; $display("FAIL reset_status got %h want 00", ram_rdat); end
    drive(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'h00) begin nfail++; $display("FAIL reset_ovf got %h want 00", ram_rdat); end
`else
    ncmp++; if (io_data !== 8'h00) begin nfail++; $display("FAIL reset_io_data got %h want 00", io_data); end
`endif
  endtask

  task automatic test_basic_rw();
    drive(8'h10, 8'h5A, 1'b1, 1'b0, 1'b0); tick();
    drive(8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'h5A) begin nfail++; $display("FAIL basic_read got %h want 5a", ram_rdat); end
    drive(8'h10, 8'h00, 1'b1, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'h00) begin nfail++; $display("FAIL basic_rd_high got %h want 00", ram_rdat); end
  endtask

  task automatic test_same_cycle();
    drive(8'h20, 8'h11, 1'b1, 1'b0, 1'b0); tick();
    drive(8'h20, 8'h22, 1'b0, 1'b0, 1'b0);
    ncmp++; if (ram_rdat !== 8'h11) begin nfail++; $display("FAIL rw_same_old got %h want 11", ram_rdat); end
    tick();
    drive(8'h20, 8'h00, 1'b0, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'h22) begin nfail++; $display("FAIL rw_same_new got %h want 22", ram_rdat); end
  endtask

`ifdef RAM_IO_FIFO_EN
  task automatic test_fifo_fill();
    for (int i = 1; i <= 5; i++) begin
      drive(8'hFF, 8'(i), 1'b1, 1'b0, 1'b0); tick();
    end
    drive(8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'h04) begin nfail++; $display("FAIL fill_status got %h want 04", ram_rdat); end
    drive(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'h01) begin nfail++; $display("FAIL fill_ovf got %h want 01", ram_rdat); end
    for (int i = 1; i <= 4; i++) begin
      drive(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
      ncmp++;
      if (io_valid !== 1'b1 || io_data !== 8'(i)) begin
        nfail++; $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, io_valid, io_data, 8'(i));
      end
      tick();
    end
    ncmp++; if (io_valid !== 1'b0) begin nfail++; $display("FAIL drain_empty got %b want 0", io_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp [5];
    exp = '{8'hB1, 8'hB2, 8'hB3, 8'hAA, 8'h00};
    for (int i = 0; i < 4; i++) begin
      drive(8'hFF, 8'hB0 + 8'(i), 1'b1, 1'b0, 1'b0); tick();
    end
    drive(8'hFF, 8'hAA, 1'b1, 1'b0, 1'b1);
    ncmp++; if (io_valid !== 1'b1 || io_data !== 8'hB0) begin nfail++; $display("FAIL fullpp_head got v=%b d=%h want v=1 d=b0", io_valid, io_data); end
    tick();
    drive(8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'h04) begin nfail++; $display("FAIL fullpp_count got %h want 04", ram_rdat); end
    drive(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'h01) begin nfail++; $display("FAIL fullpp_ovf got %h want 01", ram_rdat); end
    for (int i = 0; i < 4; i++) begin
      drive(8'h00, 8'h00, 1'b1, 1'b1, 1'b1);
      ncmp++;
      if (io_valid !== 1'b1 || io_data !== exp[i]) begin
        nfail++; $display("FAIL fullpp_drain_%0d got v=%b d=%h want v=1 d=%h", i, io_valid, io_data, exp[i]);
      end
      tick();
    end
    ncmp++; if (io_valid !== 1'b0) begin nfail++; $display("FAIL fullpp_empty got %b want 0", io_valid); end
  endtask

  task automatic test_overflow_reset();
    for (int i = 0; i < 264; i++) begin
      drive(8'hFF, 8'(i), 1'b1, 1'b0, 1'b0); tick();
    end
    drive(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'hFF) begin nfail++; $display("FAIL ovf_sat got %h want ff", ram_rdat); end
    rst = 1'b1;
    drive(8'hFF, 8'h99, 1'b1, 1'b0, 1'b1); tick();
    rst = 1'b0;
    drive(8'hFE, 8'h00, 1'b0, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'h00) begin nfail++; $display("FAIL ovfrst_status got %h want 00", ram_rdat); end
    drive(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    ncmp++; if (ram_rdat !== 8'h00) begin nfail++; $display("FAIL ovfrst_ovf got %h want 00", ram_rdat); end
    ncmp++; if (io_valid !== 1'b0) begin nfail++; $display("FAIL ovfrst_valid got %b want 0", io_valid); end
  endtask
`else
  task automatic test_plain_ff();
    drive(8'hFF, 8'h77, 1'b1, 1'b0, 1'b1); tick();
    drive(8'hFF, 8'h00, 1'b0, 1'b1, 1'b1);
    ncmp++; if (ram_rdat !== 8'h77) begin nfail++; $display("FAIL plain_ff got %h want 77", ram_rdat); end
    ncmp++; if (io_valid !== 1'b0) begin nfail++; $display("FAIL plain_valid got %b want 0", io_valid); end
    drive(8'hFE, 8'h3C, 1'b1, 1'b0, 1'b1); tick();
    drive(8'hFE, 8'h00, 1'b0, 1'b1, 1'b1);
    ncmp++; if (ram_rdat !== 8'h3C) begin nfail++; $display("FAIL plain_fe got %h want 3c", ram_rdat); end
  endtask
`endif

  task automatic test_random();
    logic [7:0] a, d, exp_rd;
    logic       rdn, wrn, rdy, r, chk;
    bit         fifo_mode, do_pop;
`ifdef RAM_IO_FIFO_EN
    fifo_mode = 1;
`else
    fifo_mode = 0;
`endif
    for (int i = 0; i < 256; i++) known_m[i] = 0;
    fifo_m.delete(); ovf_m = 0;
    rst = 1'b1; idle(); tick(); rst = 1'b0;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        8:       a = 8'hFE;
        9:       a = 8'hFF;
        default: a = 8'h80 + 8'($urandom_range(0, 7));
      endcase
      if (fifo_mode && $urandom_range(0, 2) == 0) a = 8'hFF;
      d   = 8'($urandom);
      rdn = 1'($urandom);
      wrn = 1'($urandom);
      rdy = ($urandom_range(0, 3) == 0);
      r   = ($urandom_range(0, 59) == 0);
      if (r) wrn = 1'b1;
      rst = r;
      drive(a, d, rdn, wrn, rdy);
      chk = 1'b1; exp_rd = 8'h00;
      if (!rdn) begin
        if (fifo_mode && a == 8'hFF)      exp_rd = 8'(ovf_m);
        else if (fifo_mode && a == 8'hFE) exp_rd = 8'(fifo_m.size());
        else if (known_m[a])              exp_rd = mem_m[a];
        else                              chk = 1'b0;
      end
      if (chk) begin
        ncmp++;
        if (ram_rdat !== exp_rd) begin nfail++; $display("FAIL rand_rdat n=%0d addr=%h got %h want %h", n, a, ram_rdat, exp_rd); end
      end
      ncmp++;
      if (io_valid !== (fifo_m.size() != 0)) begin nfail++; $display("FAIL rand_valid n=%0d got %b want %b", n, io_valid, fifo_m.size() != 0); end
      if (fifo_m.size() != 0) begin
        ncmp++;
        if (io_data !== fifo_m[0]) begin nfail++; $display("FAIL rand_data n=%0d got %h want %h", n, io_data, fifo_m[0]); end
      end else if (!fifo_mode) begin
        ncmp++;
        if (io_data !== 8'h00) begin nfail++; $display("FAIL rand_data_tie n=%0d got %h want 00", n, io_data); end
      end
      // model update
      if (r) begin
        fifo_m.delete(); ovf_m = 0;
      end else begin
        do_pop = (fifo_m.size() != 0) && rdy;
        if (do_pop) void'(fifo_m.pop_front());
        if (!wrn) begin
          if (fifo_mode && a == 8'hFF) begin
            if (fifo_m.size() < 4) fifo_m.push_back(d);
            else if (ovf_m < 255) ovf_m++;
          end else if (!(fifo_mode && a == 8'hFE)) begin
            mem_m[a] = d; known_m[a] = 1;
          end
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_basic_rw();
    test_same_cycle();
`ifdef RAM_IO_FIFO_EN
    test_fifo_fill();
    test_full_push_pop();
    test_overflow_reset();
`else
    test_plain_ff();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
